mem_stage_lat: RTL and testbench

Parametrised memory stage for the multi-cycle processor: owns a word-addressed data array with configurable access latency and stalls the pipeline until each load or store completes. It sits between execute and writeback. It takes the ALU-computed address and the store data, and returns load data with a one-cycle `done` strobe. Unlike a perfect-memory stage, every access costs `LAT` wait cycles, and illegal accesses are reported on `err`.

---
 rtl/mem_stage_lat.sv | 147 ++++++++++++++
 tb/tb_mem_stage_lat.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lat.sv
// Multi-cycle memory stage: word array with fixed access latency and a stall/done handshake.
// Define MEM_ALIGN_CHECK_EN to flag odd byte addresses as errors instead of ignoring bit 0.
module mem_stage_lat #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ALUresult,
    input  logic [DATA_W-1:0] read2Data,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              halt,
    output logic [DATA_W-1:0] memResult,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LAT > 2) ? $clog2(LAT) : 1;
    // LAT-1 busy cycles, but never fewer than one
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 1) ? LAT - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              bad_q, bad_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic              req;
    logic              misalign;
    logic              unused_addr;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign req         = (memRead | memWrite) & ~halt;
    assign unused_addr = ^ALUresult;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ALUresult[0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        res_d   = res_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    idx_d   = ALUresult[IDX_W:1];
                    wdata_d = read2Data;
                    rd_d    = memRead;
                    wr_d    = memWrite;
                    bad_d   = (memRead & memWrite) | misalign;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = bad_q;
                    mem_we  = wr_q & ~bad_q;
                    if (bad_q) begin
                        res_d = '0;
                    end else if (rd_q) begin
                        res_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            res_q   <= res_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Gated by rst so an aborted store is never committed
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign memResult = res_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_stage_lat.sv
// Bench for mem_stage_lat: directed steps plus random accesses vs a word-array model.
module tb_mem_stage_lat;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int NBUSY = (LAT > 1) ? LAT - 1 : 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ALUresult = '0;
    logic [15:0] read2Data = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] memResult;
    logic        stall;
    logic        done;
    logic        err;

    mem_stage_lat #(
        .DATA_W(16),
        .ADDR_W(16),
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ALUresult(ALUresult),
        .read2Data(read2Data),
        .memRead  (memRead),
        .memWrite (memWrite),
        .halt     (halt),
        .memResult(memResult),
        .stall    (stall),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] model [DEPTH];
    bit          written [DEPTH];
    logic [15:0] res_e = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    function automatic bit is_bad(input bit rd, input bit wr, input logic [15:0] a);
        bit b;
        b = rd && wr;
`ifdef MEM_ALIGN_CHECK_EN
        b = b || a[0];
`endif
        return b;
    endfunction

    task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, input bit hmid, input string tag);
        bit bad;
        int i;
        bad = is_bad(rd, wr, addr);
        i = widx(addr);
        @(negedge clk);
        memRead   = rd;
        memWrite  = wr;
        ALUresult = addr;
        read2Data = data;
        halt      = 1'b0;
        #1 chk({tag, "_stall_acc"}, stall, 1);
        if (bad) begin
            res_e = '0;
        end else begin
            if (wr) begin
                model[i] = data;
                written[i] = 1'b1;
            end
            if (rd) res_e = model[i];
        end
        for (int k = 1; k <= NBUSY + 1; k++) begin
            @(posedge clk);
            #1;
            if (k <= NBUSY) begin
                chk({tag, "_stall_busy"}, stall, 1);
                chk({tag, "_done_busy"}, done, 0);
                ALUresult = 16'($urandom);
                read2Data = 16'($urandom);
                memRead   = 1'($urandom);
                memWrite  = 1'($urandom);
                halt      = hmid;
            end else begin
                chk({tag, "_done"}, done, 1);
                chk({tag, "_stall_done"}, stall, 0);
                chk({tag, "_err"}, err, bad);
                chk({tag, "_result"}, memResult, res_e);
                memRead  = 1'b0;
                memWrite = 1'b0;
                halt     = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_err_clr"}, err, 0);
        chk({tag, "_held"}, memResult, res_e);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", memResult, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        access(0, 1, 16'h0010, 16'hBEEF, 0, "st10");
        access(1, 0, 16'h0010, 16'h0000, 0, "ld10");

        @(negedge clk);
        memRead = 1'b1;
        halt    = 1'b1;
        ALUresult = 16'h0010;
        #1 chk("halt_stall0", stall, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("halt_stall", stall, 0);
            chk("halt_done", done, 0);
        end
        memRead = 1'b0;
        halt    = 1'b0;

        access(1, 0, 16'h0010, 16'h0000, 1, "halt_mid");

        access(0, 1, 16'h0020, 16'h5A5A, 0, "st20");
        @(negedge clk);
        memWrite  = 1'b1;
        ALUresult = 16'h0020;
        read2Data = 16'h1234;
        #1 chk("abort_stall_acc", stall, 1);
        @(posedge clk);
        #1 chk("abort_stall_busy", stall, 1);
        rst      = 1'b1;
        memWrite = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done", done, 0);
        chk("abort_stall", stall, 0);
        chk("abort_result", memResult, 0);
        res_e = '0;
        rst = 1'b0;
        access(1, 0, 16'h0020, 16'h0000, 0, "ld20");

        access(0, 1, 16'h0030, 16'h7777, 0, "st30");
        access(1, 1, 16'h0030, 16'h9999, 0, "both30");
        access(1, 0, 16'h0030, 16'h0000, 0, "ld30");

        access(0, 1, 16'h0011, 16'hCAFE, 0, "st11");
        access(1, 0, 16'h0010, 16'h0000, 0, "ld10b");

        access(0, 1, 16'h0812, 16'h4321, 0, "wrap_st");
        access(1, 0, 16'h0012, 16'h0000, 0, "wrap_ld");

        for (int n = 0; n < 30; n++) begin
            bit rd, wr;
            logic [15:0] a;
            int op;
            op = int'($urandom_range(1, 3));
            rd = op[0];
            wr = op[1];
            a  = 16'($urandom_range(0, 31) * 2 + $urandom_range(0, 1));
            if (rd && !wr && !is_bad(rd, wr, a) && !written[widx(a)]) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            access(rd, wr, a, 16'($urandom), 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
